bcd_display_scan: RTL and testbench
===================================

// Module: bcd_display_scan
// PURPOSE
//  Downstream consumer of the cascaded 4-bit synchronous BCD counters. Latches NUM_DIGITS
//  BCD digits and drives a time-multiplexed 7-segment display. One digit is shown at a time,
//  and the active digit rotates every SCAN_DIV clocks. Provides leading-zero blanking,
//  shows an 'E' glyph for invalid codes (>9), and emits a frame_tick pulse once per full scan.
// PARAMETERS
//  NUM_DIGITS  4  number of BCD digits scanned (>=2)
//  SCAN_DIV    4  clocks each digit stays active (>=2)
//  LZ_BLANK    1  1 = blank leading zeros, 0 = always display every digit
// PORTS
//  clk         in   1             system clock, rising edge
//  rst         in   1             asynchronous reset, active-low
//  bcd_in      in   4*NUM_DIGITS  digit i on bcd_in[4i+3:4i]; digit 0 = least significant
//  load        in   1             1 at a clock edge: capture bcd_in into the shadow registers
//  seg         out  7             segments, active-high; seg[0]=a ... seg[6]=g
//  an          out  NUM_DIGITS    digit enable, one-hot, active-high
//  frame_tick  out  1             1-clock pulse when the scan wraps from digit NUM_DIGITS-1 to 0
// BEHAVIOUR
//  Reset (rst=0): takes effect immediately, with no clock needed.
//   - shadow digits = 0, prescaler = 0, scan_idx = 0
//   - seg = 7'h00, an = 0 (all digits off), frame_tick = 0
//   - Reset is fully asynchronous at any point in a frame, including mid-digit.
//  All outputs are registered. Every clock edge with rst=1 does the following:
//   - an  <= onehot(scan_idx)
//   - seg <= glyph(shadow[scan_idx]), using the shadow value from before this edge
//   - prescaler <= prescaler+1. If prescaler == SCAN_DIV-1: prescaler <= 0 and
//     scan_idx <= (scan_idx == NUM_DIGITS-1) ? 0 : scan_idx+1.
//   - frame_tick <= (prescaler == SCAN_DIV-1) && (scan_idx == NUM_DIGITS-1)
//   - if load: shadow <= bcd_in
//  Timing:
//   - After reset release, edges 1..SCAN_DIV show digit 0, the next SCAN_DIV edges show
//     digit 1, and so on. Period = NUM_DIGITS*SCAN_DIV clocks.
//   - frame_tick is high for exactly one clock, following edge NUM_DIGITS*SCAN_DIV of
//     each frame.
//   - load latency: a value loaded at edge k is first visible on seg at edge k+1.
//   - With load held high, the shadow registers follow bcd_in every clock.
//   - With load low, the shadow registers hold their value indefinitely.
//  glyph(): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); codes A..F give 79 ('E').
//  Leading-zero blanking (LZ_BLANK=1):
//   - Digit i>0 shows seg=00 when shadow[i] and all higher digits are 0.
//   - Digit 0 is never blanked, so an all-zero value shows a single "0".
//   - Invalid codes count as nonzero.
//   - an still asserts for blanked digits, which keeps the scan duty uniform.
//  No combinational path exists from any input to any output.
// TESTING (defaults NUM_DIGITS=4, SCAN_DIV=4, LZ_BLANK=1; 20 ns clock)
//  1. rst=0 -> seg=00, an=0000, frame_tick=0 with no clock edge; after release:
//     - edge1 gives an=0001, seg=3F
//     - digits 1..3 give seg=00
//  2. load with bcd_in=16'h1234, then scan one frame:
//     - an=0001/seg=66, an=0010/4F, an=0100/5B, an=1000/06, each held 4 clocks
//     - frame_tick pulses exactly once per 16 clocks
//  3. bcd_in=16'h0050:
//     - digits 3,2 give seg=00, digit1 gives 6D, digit0 gives 3F
//     - rebuild with LZ_BLANK=0: digits 3,2 give 3F
//  4. bcd_in=16'h00A7:
//     - digit1 gives 79 ('E'), digit0 gives 07
//     - digits 3,2 are blanked; digit1 is not blanked despite being above zeros
//  5. Hold load=1 while a live BCD counter drives digit 0 (0..9 wrap):
//     - digit-0 seg tracks the counter one clock later
//     - then drop load=0: the value freezes across 3 frames
//  6. Assert rst low mid-frame (scan_idx=2, prescaler=1):
//     - outputs clear asynchronously
//     - after release the scan restarts at digit 0 and the display shows "0"

Source files
------------

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner for a bank of latched BCD digits.
// Ports: clk, rst (async active-low), bcd_in/load -> shadow, seg/an/frame_tick out.
module bcd_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4,
  parameter bit LZ_BLANK   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [PW-1:0]           pre;
  logic [SW-1:0]           idx;

  logic [3:0]            dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] nz_up;
  logic                  nz_acc;
  logic [3:0]            cur;
  logic                  blank;
  logic [6:0]            glyph;
  logic                  pre_wrap;
  logic                  idx_wrap;

  // nz_up[i]: digit i or any more significant digit is nonzero
  always_comb begin
    nz_acc = 1'b0;
    nz_up  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig[i]   = shadow[4*i +: 4];
      nz_acc   = nz_acc | (dig[i] != 4'd0);
      nz_up[i] = nz_acc;
    end
  end

  always_comb begin
    cur   = dig[idx];
    blank = LZ_BLANK && (idx != '0) && !nz_up[idx];
  end

  always_comb begin
    unique case (cur)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h79;
    endcase
  end

  assign pre_wrap = (pre == PRE_LAST);
  assign idx_wrap = (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow     <= '0;
      pre        <= '0;
      idx        <= '0;
      seg        <= 7'h00;
      an         <= '0;
      frame_tick <= 1'b0;
    end else begin
      an         <= NUM_DIGITS'(1) << idx;
      seg        <= blank ? 7'h00 : glyph;
      frame_tick <= pre_wrap && idx_wrap;
      if (pre_wrap) begin
        pre <= '0;
        idx <= idx_wrap ? '0 : idx + SW'(1);
      end else begin
        pre <= pre + PW'(1);
      end
      if (load) shadow <= bcd_in;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: blanking and non-blanking builds
// share stimulus; every edge of each frame is checked against hand values.
module tb_bcd_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic [6:0]  seg, seg_nb;
  logic [3:0]  an, an_nb;
  logic        frame_tick, frame_tick_nb;

  int n_run;
  int n_fail;

  bcd_display_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  bcd_display_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg_nb), .an(an_nb), .frame_tick(frame_tick_nb)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] gl(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  // exp/exp_nb pack digit d glyph at [7d+6:7d]; optional load at edge 16
  task automatic run_frame(input logic [15:0] nxt, input logic ld_last,
                           input logic [27:0] exp, input logic [27:0] exp_nb);
    int d;
    for (int e = 0; e < 16; e++) begin
      d = e / 4;
      if (e == 15 && ld_last) begin
        bcd_in = nxt;
        load   = 1'b1;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      chk("an", 32'(an), 32'(4'b0001 << d));
      chk("seg", 32'(seg), 32'(exp[7*d +: 7]));
      chk("an_nb", 32'(an_nb), 32'(4'b0001 << d));
      chk("seg_nb", 32'(seg_nb), 32'(exp_nb[7*d +: 7]));
      chk("tick", 32'(frame_tick), 32'(e == 15));
      chk("tick_nb", 32'(frame_tick_nb), 32'(e == 15));
    end
  endtask

  initial begin
    logic [3:0] cnt;
    logic [3:0] prev;
    int d;
    n_run  = 0;
    n_fail = 0;
    bcd_in = 16'h0;
    load   = 1'b0;
    rst    = 1'b1;
    #2 rst = 1'b0;
    #3;
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_seg_nb", 32'(seg_nb), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // all-zero shadow: a single "0" in the blanking build
    run_frame(16'h1234, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F},
              {7'h3F, 7'h3F, 7'h3F, 7'h3F});
    run_frame(16'h1234, 1'b1, {7'h06, 7'h5B, 7'h4F, 7'h66},
              {7'h06, 7'h5B, 7'h4F, 7'h66});
    run_frame(16'h0050, 1'b1, {7'h06, 7'h5B, 7'h4F, 7'h66},
              {7'h06, 7'h5B, 7'h4F, 7'h66});
    run_frame(16'h00A7, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F},
              {7'h3F, 7'h3F, 7'h6D, 7'h3F});
    run_frame(16'h0000, 1'b1, {7'h00, 7'h00, 7'h79, 7'h07},
              {7'h3F, 7'h3F, 7'h79, 7'h07});

    // live decade counter on digit 0 with load held high
    cnt  = 4'd0;
    prev = 4'd0;
    for (int f = 0; f < 3; f++) begin
      for (int e = 0; e < 16; e++) begin
        d      = e / 4;
        cnt    = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        bcd_in = {12'h000, cnt};
        load   = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt_an", 32'(an), 32'(4'b0001 << d));
        chk("cnt_seg", 32'(seg), (d == 0) ? 32'(gl(prev)) : 32'h00);
        chk("cnt_seg_nb", 32'(seg_nb), (d == 0) ? 32'(gl(prev)) : 32'h3F);
        chk("cnt_tick", 32'(frame_tick), 32'(e == 15));
        prev = cnt;
      end
    end
    load   = 1'b0;
    bcd_in = 16'h9999;
    for (int f = 0; f < 3; f++)
      run_frame(16'h0, 1'b0, {7'h00, 7'h00, 7'h00, gl(prev)},
                {7'h3F, 7'h3F, 7'h3F, gl(prev)});

    // stop mid-frame at scan_idx=2, prescaler=1, then reset
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_an", 32'(an), 32'h4);
    #4 rst = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(seg), 32'h00);
    chk("mid_rst_an", 32'(an), 32'h0);
    chk("mid_rst_tick", 32'(frame_tick), 32'h0);
    chk("mid_rst_an_nb", 32'(an_nb), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_frame(16'h0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F},
              {7'h3F, 7'h3F, 7'h3F, 7'h3F});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
